// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the sensor front end and the conditioner core.
// The master drives the raw comparator/float levels and the clear request;
// the slave returns the conditioned levels, the fault flag and the update strobe.
interface sensor_conditioner_if;
    logic raw_a;
    logic raw_m;
    logic raw_b;
    logic raw_us;
    logic raw_ua;
    logic raw_t;
    logic fault_clr;
    logic a;
    logic m;
    logic b;
    logic us;
    logic ua;
    logic t;
    logic level_fault;
    logic upd;

    modport master (
        output raw_a, raw_m, raw_b, raw_us, raw_ua, raw_t, fault_clr,
        input  a, m, b, us, ua, t, level_fault, upd
    );

    modport slave (
        input  raw_a, raw_m, raw_b, raw_us, raw_ua, raw_t, fault_clr,
        output a, m, b, us, ua, t, level_fault, upd
    );
endinterface

// File: rtl/sensor_conditioner.sv
// Sensor conditioner: synchronizes and debounces six slow sensor levels,
// checks the three tank floats for physical consistency and raises a sticky
// fault that forces the tank reading to "empty" until it is cleared.
//
// Fault FSM
//   state    | meaning
//   ST_OK    | tank readings trusted, a/m/b follow the debounced floats
//   ST_FAULT | floats inconsistent too long, a/m/b forced to 0 until cleared
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FAULT_CYCLES    = 8
) (
    input logic             clk,
    input logic             rst,
    sensor_conditioner_if.slave bus
);
    // Channel order in every packed vector: 0=a, 1=m, 2=b, 3=us, 4=ua, 5=t.
    localparam int unsigned N_IN    = 6;
    localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  FLT_MAX = 8'(FAULT_CYCLES);

    typedef enum logic {ST_OK, ST_FAULT} state_t;

    logic [N_IN-1:0]       raw;
    logic [N_IN-1:0]       sync1;
    logic [N_IN-1:0]       sync2;
    logic [N_IN-1:0]       stable;
    logic [N_IN-1:0][7:0]  db_cnt;
    logic [7:0]            flt_cnt;
    state_t                state;
    state_t                state_next;
    logic                  inconsistent;
    logic                  detect;
    logic                  level_fault;
    logic [6:0]            outs;
    logic [6:0]            outs_prev;
    logic                  upd;

    assign raw = {bus.raw_t, bus.raw_ua, bus.raw_us, bus.raw_b, bus.raw_m, bus.raw_a};

    // Two-flop synchronizer for every asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce: count disagreeing cycles, accept after DEBOUNCE_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // A float above the water while one below is dry cannot happen physically.
    assign inconsistent = (stable[0] & ~stable[1]) | (stable[1] & ~stable[2]);
    assign detect       = (flt_cnt == FLT_MAX);

    // Consecutive-inconsistent-cycle counter, saturating at FAULT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt <= '0;
        end else if (!inconsistent) begin
            flt_cnt <= '0;
        end else if (flt_cnt != FLT_MAX) begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end

    // Fault FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_OK;
        end else begin
            state <= state_next;
        end
    end

    // Fault FSM next state; a fresh detection always beats a clear request.
    always_comb begin
        state_next = state;
        case (state)
            ST_OK: begin
                if (detect) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr && !inconsistent && !detect) begin
                    state_next = ST_OK;
                end
            end
            default: state_next = ST_OK;
        endcase
    end

    assign level_fault = (state == ST_FAULT);
    assign outs = {level_fault, stable[5:3], level_fault ? 3'b000 : stable[2:0]};

    // Change detector: one upd pulse the cycle after any visible output moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            outs_prev <= '0;
            upd       <= 1'b0;
        end else begin
            outs_prev <= outs;
            upd       <= (outs != outs_prev);
        end
    end

    assign bus.a           = outs[0];
    assign bus.m           = outs[1];
    assign bus.b           = outs[2];
    assign bus.us          = outs[3];
    assign bus.ua          = outs[4];
    assign bus.t           = outs[5];
    assign bus.level_fault = outs[6];
    assign bus.upd         = upd;
endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios with fixed timing
// expectations, then randomized input activity, all checked every cycle
// against a timestamp-based reference model of the conditioning rules.
module tb_sensor_conditioner;
    localparam int D = 4;
    localparam int F = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    sensor_conditioner_if ifc ();

    sensor_conditioner #(.DEBOUNCE_CYCLES(D), .FAULT_CYCLES(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Reference model state: raw samples per edge, and for each channel the
    // cycle at which the current disagreement with the accepted level began.
    bit [5:0] raw_q[$];
    bit [5:0] m_stable;
    int       m_since[6];
    int       m_frun;
    bit       m_fault;
    bit [6:0] m_out_last;
    bit       m_upd;
    int       cyc;

    function automatic bit [6:0] out_of(input bit [5:0] st, input bit flt);
        return {flt, st[5:3], flt ? 3'b000 : st[2:0]};
    endfunction

    function automatic bit [5:0] raw_now();
        return {ifc.raw_t, ifc.raw_ua, ifc.raw_us, ifc.raw_b, ifc.raw_m, ifc.raw_a};
    endfunction

    function automatic void model_step();
        bit [5:0] sync;
        bit [5:0] st_next;
        bit [6:0] pre_out;
        bit       incons;
        bit       det;
        if (rst) begin
            raw_q.delete();
            m_stable   = '0;
            m_frun     = 0;
            m_fault    = 1'b0;
            m_out_last = '0;
            m_upd      = 1'b0;
            cyc        = 0;
            for (int i = 0; i < 6; i++) m_since[i] = -1;
            return;
        end
        pre_out    = out_of(m_stable, m_fault);
        m_upd      = (pre_out != m_out_last);
        m_out_last = pre_out;
        sync   = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 6'b0;
        incons = (m_stable[0] && !m_stable[1]) || (m_stable[1] && !m_stable[2]);
        det    = (m_frun == F);
        if (!m_fault && det) m_fault = 1'b1;
        else if (m_fault && ifc.fault_clr && !incons && !det) m_fault = 1'b0;
        m_frun  = incons ? ((m_frun + 1 > F) ? F : m_frun + 1) : 0;
        st_next = m_stable;
        for (int i = 0; i < 6; i++) begin
            if (sync[i] == m_stable[i]) begin
                m_since[i] = -1;
            end else begin
                if (m_since[i] < 0) m_since[i] = cyc;
                if (cyc - m_since[i] >= D - 1) begin
                    st_next[i] = sync[i];
                    m_since[i] = -1;
                end
            end
        end
        m_stable = st_next;
        raw_q.push_back(raw_now());
        cyc++;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {ifc.upd, ifc.level_fault, ifc.t, ifc.ua, ifc.us, ifc.b, ifc.m, ifc.a};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", dut_vec(), {m_upd, out_of(m_stable, m_fault)});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int       pulses;
        int       hold[6];
        bit [5:0] rv;

        ifc.raw_a = 0; ifc.raw_m = 0; ifc.raw_b = 0;
        ifc.raw_us = 0; ifc.raw_ua = 0; ifc.raw_t = 0;
        ifc.fault_clr = 0;
        rst = 1'b1;
        run(3);
        check("reset_outputs", dut_vec(), 8'h00);

        // Scenario 1: release reset at cycle 0, raw_us rises at cycle 10.
        rst = 1'b0;
        tick();
        check("s1_no_upd_after_reset", {7'd0, ifc.upd}, 8'd0);
        run(9);
        ifc.raw_us = 1;
        run(5);
        check("s1_us_cycle15", {7'd0, ifc.us}, 8'd0);
        tick();
        check("s1_us_cycle16", {7'd0, ifc.us}, 8'd1);
        check("s1_upd_cycle16", {7'd0, ifc.upd}, 8'd0);
        tick();
        check("s1_upd_cycle17", {7'd0, ifc.upd}, 8'd1);
        tick();
        check("s1_upd_cycle18", {7'd0, ifc.upd}, 8'd0);

        // Scenario 2: three-cycle glitch on raw_t is rejected.
        ifc.raw_t = 1;
        run(3);
        ifc.raw_t = 0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            pulses += int'(ifc.upd);
        end
        check("s2_t_low", {7'd0, ifc.t}, 8'd0);
        check("s2_no_upd", 8'(pulses), 8'd0);

        // Scenario 3: all three floats rise together.
        ifc.raw_a = 1; ifc.raw_m = 1; ifc.raw_b = 1;
        run(5);
        check("s3_abm_early", {5'd0, ifc.b, ifc.m, ifc.a}, 8'd0);
        tick();
        check("s3_abm_set", {5'd0, ifc.b, ifc.m, ifc.a}, 8'd7);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            pulses += int'(ifc.upd);
        end
        check("s3_single_upd", 8'(pulses), 8'd1);
        check("s3_no_fault", {7'd0, ifc.level_fault}, 8'd0);

        // Scenario 4: M=1, B=0 held until fault; clear ignored while inconsistent.
        ifc.raw_b = 0;
        run(6);
        check("s4_b_dropped", {5'd0, ifc.b, ifc.m, ifc.a}, 8'd3);
        run(8);
        check("s4_fault_not_yet", {7'd0, ifc.level_fault}, 8'd0);
        tick();
        check("s4_fault_set", {7'd0, ifc.level_fault}, 8'd1);
        check("s4_abm_forced", {5'd0, ifc.b, ifc.m, ifc.a}, 8'd0);
        ifc.fault_clr = 1;
        tick();
        ifc.fault_clr = 0;
        check("s4_clr_ignored", {7'd0, ifc.level_fault}, 8'd1);
        check("s4_upd_on_fault", {7'd0, ifc.upd}, 8'd1);
        run(3);
        check("s4_fault_sticky", {7'd0, ifc.level_fault}, 8'd1);

        // Scenario 5: restore B, then clear.
        ifc.raw_b = 1;
        run(8);
        check("s5_still_fault", {4'd0, ifc.level_fault, ifc.b, ifc.m, ifc.a}, 8'b0000_1000);
        ifc.fault_clr = 1;
        tick();
        ifc.fault_clr = 0;
        check("s5_cleared", {4'd0, ifc.level_fault, ifc.b, ifc.m, ifc.a}, 8'b0000_0111);
        tick();
        check("s5_upd", {7'd0, ifc.upd}, 8'd1);
        tick();
        check("s5_upd_once", {7'd0, ifc.upd}, 8'd0);

        // Scenario 6: reset mid-debounce of raw_ua discards the partial count.
        ifc.raw_ua = 1;
        run(3);
        rst = 1'b1;
        tick();
        check("s6_reset_outputs", dut_vec(), 8'h00);
        rst = 1'b0;
        tick();
        check("s6_no_upd_after_reset", {7'd0, ifc.upd}, 8'd0);
        run(4);
        check("s6_ua_cycle5", {7'd0, ifc.ua}, 8'd0);
        tick();
        check("s6_ua_cycle6", {7'd0, ifc.ua}, 8'd1);

        // Randomized activity: mixed glitches and long holds, clears, rare resets.
        for (int i = 0; i < 6; i++) hold[i] = $urandom_range(1, 10);
        rv = raw_now();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 6; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    rv[i]   = ~rv[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D + 1)
                                                          : $urandom_range(D + 3, 30);
                end
            end
            {ifc.raw_t, ifc.raw_ua, ifc.raw_us, ifc.raw_b, ifc.raw_m, ifc.raw_a} = rv;
            ifc.fault_clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        ifc.fault_clr = 0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the consecutive-cycle count required to accept a new input level; legal range 2..255.
REQ-003 Parameter FAULT_CYCLES, default 8, SHALL set the consecutive-cycle count of inconsistent tank levels required to declare a fault; legal range 1..255.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 raw_a, raw_m, raw_b  input  1 each  asynchronous tank float switches: high, mid and low.
REQ-007 raw_us, raw_ua, raw_t  input  1 each  asynchronous soil-humidity, air-humidity and temperature comparators.
REQ-008 fault_clr  input  1  synchronous single-cycle request to clear level_fault.
REQ-009 a, m, b, us, ua, t  output  1 each  conditioned levels that feed the alarm, valve and irrigation logic downstream.
REQ-010 level_fault  output  1  sticky tank-sensor inconsistency flag.
REQ-011 upd  output  1  single-cycle strobe marking a change of any conditioned output.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Each input SHALL own a debounce counter and a stable register; the counter SHALL clear whenever the synchronized value equals the stable value.
REQ-014 While the synchronized value differs from the stable value, the counter SHALL increment by one each cycle.
REQ-015 In the cycle the counter reaches DEBOUNCE_CYCLES-1 with the values still differing, the stable register SHALL load the synchronized value at the next edge, and the counter SHALL clear.
REQ-016 A raw level held constant from cycle N SHALL appear on the stable register at cycle N+2+DEBOUNCE_CYCLES.
REQ-017 A raw excursion shorter than DEBOUNCE_CYCLES cycles, measured after synchronization, SHALL leave the stable register unchanged and SHALL clear the counter on its return.
REQ-018 us, ua and t SHALL equal their stable registers.
REQ-019 A stable tank state SHALL be inconsistent when (A=1 and M=0) or (M=1 and B=0).
REQ-020 A fault counter SHALL increment each cycle the stable tank state is inconsistent, SHALL clear on any consistent cycle, and SHALL saturate at FAULT_CYCLES.
REQ-021 level_fault SHALL rise on the edge after the fault counter reaches FAULT_CYCLES.
REQ-022 level_fault SHALL stay high until reset or until fault_clr is sampled high while the stable tank state is consistent.
REQ-023 When fault_clr arrives while the stable tank state is inconsistent, the block SHALL ignore the request.
REQ-024 If fault detection and fault_clr occur in the same cycle, detection SHALL win and level_fault SHALL remain 1.
REQ-025 While level_fault=1, a, m and b SHALL be forced to 0 (empty tank, so the downstream alarm asserts).
REQ-026 While level_fault=0, a, m and b SHALL equal their stable registers.
REQ-027 upd SHALL pulse high for exactly one cycle, one cycle after any of a, m, b, us, ua, t or level_fault changes value.
REQ-028 If several of those outputs change in the same cycle, upd SHALL produce a single pulse.

Reset
REQ-029 When rst=1, all synchronizer flops, stable registers, counters and level_fault SHALL be 0 at the next edge.
REQ-030 Output values with rst=1 SHALL be a=m=b=us=ua=t=0, level_fault=0 and upd=0.
REQ-031 Reset asserted mid-debounce or mid-fault-count SHALL discard the partial count.
REQ-032 After reset, every input SHALL need the full DEBOUNCE_CYCLES interval again before its output changes.
REQ-033 upd SHALL NOT pulse on the first cycle after reset is released.

Verification (DEBOUNCE_CYCLES=4, FAULT_CYCLES=8)
REQ-034 Scenario 1: release rst at cycle 0, raw_us 0->1 at cycle 10 and held -> us=1 at cycle 16, upd=1 at cycle 17 only.
REQ-035 Scenario 2: raw_t high for 3 cycles then low -> t stays 0 and upd never pulses.
REQ-036 Scenario 3: raw_b, raw_m and raw_a rise together and are held -> b=m=a=1 in the same cycle, a single upd pulse, level_fault=0.
REQ-037 Scenario 4: stable tank state M=1, B=0 held -> level_fault=1 after 8 inconsistent cycles, a=m=b=0; fault_clr pulsed while still inconsistent -> level_fault stays 1.
REQ-038 Scenario 5: restore B=1 (consistent) and pulse fault_clr -> level_fault=0 on the next edge, a/m/b show stable values, one upd pulse.
REQ-039 Scenario 6: rst pulsed while raw_ua has been high for 2 post-sync cycles -> ua=0, and ua=1 only 6 cycles after reset release with raw_ua held high.
